// File: rtl/tri_frame_reader_pkg.sv
// Shared triple-buffer definitions: buffer indices, selection codes, reader states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: buf_idx_t (X/Y/Z), sel_code_t (A..F), rd_state_t, disp_sel_t and
// disp_buf(), which maps a selection code to the buffer the display owns. The
// controller uses the same function so both ends always agree on the mapping.
package tri_buf_pkg;

  typedef enum logic [1:0] {
    BUF_X = 2'd0,
    BUF_Y = 2'd1,
    BUF_Z = 2'd2
  } buf_idx_t;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5
  } sel_code_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic     vld;
    buf_idx_t idx;
  } disp_sel_t;

  // Display-owned buffer for each selection code; codes 6 and 7 are invalid.
  function automatic disp_sel_t disp_buf(input logic [2:0] sel);
    disp_sel_t r;
    r.vld = 1'b1;
    r.idx = BUF_X;
    case (sel)
      SEL_A:   r.idx = BUF_Y;
      SEL_B:   r.idx = BUF_Z;
      SEL_C:   r.idx = BUF_X;
      SEL_D:   r.idx = BUF_Z;
      SEL_E:   r.idx = BUF_X;
      SEL_F:   r.idx = BUF_Y;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // One-hot SRAM strobe for a buffer index (bit0=X, bit1=Y, bit2=Z).
  function automatic logic [2:0] buf_onehot(input buf_idx_t idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/tri_frame_reader_if.sv
// Bundles the reader's SRAM read port and its pixel stream to the VGA block.
// Latency: n/a (wiring only).
// Backpressure: pix_ready from the slave stalls the pixel stream.
// master = reader side (drives rd_en/rd_addr/pix_valid/pix_data),
// slave  = SRAM+VGA side (drives rd_data_x/y/z and pix_ready).
interface tri_frame_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [2:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_x;
  logic [DATA_W-1:0] rd_data_y;
  logic [DATA_W-1:0] rd_data_z;

  modport master (
    output pix_valid, pix_data, rd_en, rd_addr,
    input  pix_ready, rd_data_x, rd_data_y, rd_data_z
  );

  modport slave (
    input  pix_valid, pix_data, rd_en, rd_addr,
    output pix_ready, rd_data_x, rd_data_y, rd_data_z
  );
endinterface

// File: rtl/tri_pix_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes on full are dropped unless a pop happens the same cycle.
// Ports: clk, reset (async active-low), flush, push/push_dat, pop,
//        head (zero when empty), empty, count.
module tri_pix_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty & ~flush;
  // On full, a same-cycle pop frees the slot being written.
  assign push_ok = push & ~flush & (~full | pop_ok);

  // Head forced to zero when empty so the output is clean straight out of reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/tri_frame_reader.sv
// Display read engine: streams the display-owned SRAM of the triple buffer to VGA.
// Latency: first pixel RD_LATENCY+1 clocks after the frame_start sampling edge.
// Backpressure: pix_ready stalls pops; reads stop once FIFO + in-flight fill the FIFO.
// Ports: clk, reset (async active-low), sram_select/frame_start (frame control),
//        frame_done (pulse after last pop), error (sticky bad select),
//        bus (master side: rd_en/rd_addr/rd_data_x/y/z, pix_valid/pix_ready/pix_data).
module tri_frame_reader
  import tri_buf_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int FRAME_PIXELS = 76800,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          sram_select,
  input  logic                frame_start,
  output logic                frame_done,
  output logic                error,
  tri_frame_reader_if.master  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] FRAME_CNT  = ADDR_W'(FRAME_PIXELS);

  rd_state_t              state;
  buf_idx_t               cur_buf;
  disp_sel_t              sel_dec;
  logic [ADDR_W-1:0]      issue_cnt;
  logic [ADDR_W-1:0]      pop_cnt;
  logic [RD_LATENCY-1:0]  tags;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_head;
  logic [DATA_W-1:0]      ret_dat;
  logic                   push;
  logic                   pop;
  logic                   can_issue;
  int                     outstanding;

  assign sel_dec = disp_buf(sram_select);

  always_comb begin
    ret_dat = bus.rd_data_x;
    case (cur_buf)
      BUF_Y:   ret_dat = bus.rd_data_y;
      BUF_Z:   ret_dat = bus.rd_data_z;
      default: ret_dat = bus.rd_data_x;
    endcase
  end

  // Every read already committed: FIFO occupancy, the read on the bus this
  // cycle, and tags still travelling the latency pipe. Keeping this below
  // FIFO_DEPTH reserves a slot for every return, so the FIFO cannot overflow.
  always_comb begin
    outstanding = int'(fifo_count) + int'(|bus.rd_en);
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + int'(tags[i]);
    end
  end

  assign can_issue = (outstanding < FIFO_DEPTH);

  // frame_start discards whatever is emerging from the pipe that cycle.
  assign push = tags[RD_LATENCY-1] & ~frame_start;
  assign pop  = ~fifo_empty & bus.pix_ready;

  assign bus.pix_valid = ~fifo_empty;
  assign bus.pix_data  = fifo_head;

  tri_pix_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (frame_start),
    .push     (push),
    .push_dat (ret_dat),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // tags[RD_LATENCY-1] lines up with the SRAM data of the read issued
  // RD_LATENCY cycles earlier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags <= '0;
    end else if (frame_start) begin
      tags <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        tags[i] <= tags[i-1];
      end
      tags[0] <= |bus.rd_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RD_IDLE;
      cur_buf     <= BUF_X;
      issue_cnt   <= '0;
      pop_cnt     <= '0;
      bus.rd_en   <= '0;
      bus.rd_addr <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else if (frame_start) begin
      // Start or abort: the first read of the new frame goes out next cycle.
      frame_done <= 1'b0;
      pop_cnt    <= '0;
      if (sel_dec.vld) begin
        cur_buf     <= sel_dec.idx;
        bus.rd_en   <= buf_onehot(sel_dec.idx);
        bus.rd_addr <= '0;
        issue_cnt   <= ADDR_W'(1);
        state       <= (FRAME_PIXELS == 1) ? RD_DRAIN : RD_FETCH;
      end else begin
        error     <= 1'b1;
        bus.rd_en <= '0;
        state     <= RD_IDLE;
      end
    end else begin
      pop_cnt <= pop_cnt + ADDR_W'(pop);
      case (state)
        RD_IDLE: begin
          bus.rd_en  <= '0;
          frame_done <= 1'b0;
        end
        RD_FETCH: begin
          if (can_issue) begin
            bus.rd_en   <= buf_onehot(cur_buf);
            bus.rd_addr <= issue_cnt;
            issue_cnt   <= issue_cnt + ADDR_W'(1);
            if (issue_cnt == LAST_ADDR) state <= RD_DRAIN;
          end else begin
            bus.rd_en <= '0;
          end
        end
        RD_DRAIN: begin
          bus.rd_en <= '0;
          if (pop_cnt == FRAME_CNT) begin
            state      <= RD_DONE;
            frame_done <= 1'b1;
          end
        end
        RD_DONE: begin
          bus.rd_en  <= '0;
          frame_done <= 1'b0;
          state      <= RD_IDLE;
        end
        default: begin
          bus.rd_en <= '0;
          state     <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_frame_reader.sv
// Directed bench for tri_frame_reader with a 16-pixel frame and 2-cycle SRAMs.
// Latency: n/a.
// Backpressure: pix_ready driven directly by the bench.
module tb_tri_frame_reader;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int FP     = 16;
  localparam int RL     = 2;
  localparam int FD     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sram_select = 3'd0;
  logic       frame_start = 1'b0;
  logic       frame_done;
  logic       error;

  tri_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tri_frame_reader #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FRAME_PIXELS (FP),
    .RD_LATENCY   (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_select (sram_select),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .error       (error),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: word at addr in buffer b is addr + 0x100*b; 0xDEAD when not strobed.
  logic [DATA_W-1:0] s1 [3];
  logic [DATA_W-1:0] s2 [3];
  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      s1[b] <= bus.rd_en[b] ? (DATA_W'(bus.rd_addr) + DATA_W'(b * 256)) : 16'hDEAD;
      s2[b] <= s1[b];
    end
  end
  assign bus.rd_data_x = s2[0];
  assign bus.rd_data_y = s2[1];
  assign bus.rd_data_z = s2[2];

  // Monitor on the falling edge, where everything is stable for the cycle.
  logic [2:0]        iss_en_q   [$];
  logic [ADDR_W-1:0] iss_addr_q [$];
  logic [DATA_W-1:0] got_q      [$];
  int done_cnt    = 0;
  int done_at     = -1;
  int first_valid = -1;
  int fs_edge     = 0;

  always @(negedge clk) begin
    if (bus.rd_en != 3'b000) begin
      iss_en_q.push_back(bus.rd_en);
      iss_addr_q.push_back(bus.rd_addr);
    end
    if (bus.pix_valid && first_valid < 0) first_valid = cyc;
    if (bus.pix_valid && bus.pix_ready) got_q.push_back(bus.pix_data);
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_at  = got_q.size();
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle frame_start; monitors are cleared at the sampling edge so
  // they only hold activity of the new frame. fs_edge = cycle count after that edge.
  task automatic pulse(input logic [2:0] sel);
    sram_select = sel;
    frame_start = 1'b1;
    @(posedge clk);
    iss_en_q.delete();
    iss_addr_q.delete();
    got_q.delete();
    done_cnt    = 0;
    done_at     = -1;
    first_valid = -1;
    #1;
    frame_start = 1'b0;
    fs_edge     = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " frame_done seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic verify_frame(input string tag, input logic [2:0] en, input int bidx);
    int bad = 0;
    check({tag, " issue count"}, iss_en_q.size(), FP);
    for (int i = 0; i < iss_en_q.size(); i++) begin
      if (iss_en_q[i] !== en || iss_addr_q[i] !== ADDR_W'(i)) bad++;
    end
    check({tag, " issue strobe/addr errors"}, bad, 0);
    check({tag, " pixel count"}, got_q.size(), FP);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== DATA_W'(i + 256 * bidx)) bad++;
    end
    check({tag, " pixel data errors"}, bad, 0);
    check({tag, " frame_done pulses"}, done_cnt, 1);
    check({tag, " pops before frame_done"}, done_at, FP);
  endtask

  logic [2:0] t2_en [5] = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
  int         t2_b  [5] = '{2, 0, 2, 0, 1};

  initial begin
    bus.pix_ready = 1'b0;
    repeat (3) tick();

    // Reset values.
    check("rst rd_en", bus.rd_en, 3'b000);
    check("rst rd_addr", bus.rd_addr, 0);
    check("rst pix_valid", bus.pix_valid, 0);
    check("rst pix_data", bus.pix_data, 0);
    check("rst frame_done", frame_done, 0);
    check("rst error", error, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Basic frame from Y; first pixel 3 edges after the frame_start edge.
    bus.pix_ready = 1'b1;
    pulse(3'd0);
    check("t1 first rd_en", bus.rd_en, 3'b010);
    check("t1 first rd_addr", bus.rd_addr, 0);
    wait_done("t1");
    verify_frame("t1", 3'b010, 1);
    check("t1 latency", first_valid - fs_edge, RL + 1);
    check("t1 idle rd_en", bus.rd_en, 3'b000);
    check("t1 idle frame_done", frame_done, 0);

    // Decode sweep.
    for (int s = 1; s <= 5; s++) begin
      pulse(3'(s));
      check($sformatf("t2 sel%0d first rd_en", s), bus.rd_en, t2_en[s-1]);
      wait_done($sformatf("t2 sel%0d", s));
      verify_frame($sformatf("t2 sel%0d", s), t2_en[s-1], t2_b[s-1]);
      check($sformatf("t2 sel%0d error", s), error, 0);
    end

    // Invalid select, then recovery.
    pulse(3'd6);
    repeat (10) tick();
    check("t3 error set", error, 1);
    check("t3 no issues", iss_en_q.size(), 0);
    check("t3 rd_en", bus.rd_en, 3'b000);
    check("t3 pix_valid", bus.pix_valid, 0);
    pulse(3'd0);
    wait_done("t3 recover");
    verify_frame("t3 recover", 3'b010, 1);
    check("t3 error sticky", error, 1);

    // Backpressure: only FIFO_DEPTH reads while stalled.
    bus.pix_ready = 1'b0;
    pulse(3'd0);
    repeat (20) tick();
    check("t4 stalled issues", iss_en_q.size(), FD);
    check("t4 stalled rd_en", bus.rd_en, 3'b000);
    check("t4 stalled pops", got_q.size(), 0);
    check("t4 stalled pix_valid", bus.pix_valid, 1);
    bus.pix_ready = 1'b1;
    wait_done("t4");
    verify_frame("t4", 3'b010, 1);

    // Select changes mid-frame are ignored until the next frame_start.
    pulse(3'd0);
    repeat (3) tick();
    sram_select = 3'd1;
    wait_done("t5");
    verify_frame("t5", 3'b010, 1);
    pulse(3'd1);
    check("t5 next rd_en", bus.rd_en, 3'b100);
    wait_done("t5 next");
    verify_frame("t5 next", 3'b100, 2);

    // Abort mid-frame with reads in flight; new frame from X must be clean.
    pulse(3'd0);
    begin
      int n = 0;
      while (iss_en_q.size() < 5 && n < 50) begin
        tick();
        n++;
      end
    end
    check("t6 reads before abort", 32'(iss_en_q.size() >= 5), 1);
    pulse(3'd2);
    check("t6 restart rd_en", bus.rd_en, 3'b001);
    check("t6 restart rd_addr", bus.rd_addr, 0);
    wait_done("t6");
    verify_frame("t6", 3'b001, 0);

    // Asynchronous reset mid-frame.
    pulse(3'd0);
    repeat (6) tick();
    check("t7 busy pix_valid", bus.pix_valid, 1);
    check("t7 busy rd_addr nonzero", 32'(bus.rd_addr != 0), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t7 async rd_en", bus.rd_en, 3'b000);
    check("t7 async rd_addr", bus.rd_addr, 0);
    check("t7 async pix_valid", bus.pix_valid, 0);
    check("t7 async pix_data", bus.pix_data, 0);
    check("t7 async frame_done", frame_done, 0);
    check("t7 async error", error, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
